// File: rtl/ddr3_sched_pkg.sv
// Shared types and constants for the closed-page DDR3 command scheduler.
// Timing defaults are in CLK cycles; widths match the command SM address bus.
package ddr3_sched_pkg;

    localparam int unsigned BA_W  = 3;
    localparam int unsigned ROW_W = 15;
    localparam int unsigned COL_W = 10;
    localparam int unsigned DQ_W  = 16;

    localparam int unsigned DEF_T_RCD  = 4;
    localparam int unsigned DEF_T_WR   = 6;
    localparam int unsigned DEF_T_RTP  = 4;
    localparam int unsigned DEF_T_RP   = 4;
    localparam int unsigned DEF_T_RFC  = 16;
    localparam int unsigned DEF_T_REFI = 780;

    localparam int unsigned WAIT_W = 16;

    typedef enum logic [3:0] {
        StIdle,
        StAct,
        StWaitRcd,
        StRw,
        StWaitRw,
        StPre,
        StWaitRp,
        StRef,
        StWaitRfc
    } state_e;

    // Loaded in a pulse state so that the following wait state lasts cycles-1 cycles,
    // putting the next pulse exactly 'cycles' after the current one.
    function automatic logic [WAIT_W-1:0] wait_load(input int unsigned cycles);
        return (cycles >= 2) ? WAIT_W'(cycles - 2) : '0;
    endfunction

endpackage

// File: rtl/ddr3_wait_timer.sv
// Loadable down-counter shared by all wait states of the scheduler.
// expired_o is high whenever the count has reached zero.
module ddr3_wait_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/ddr3_cmd_scheduler.sv
// Closed-page DDR3 command scheduler: ACT -> READ/WRITE -> PRE sequencing per request,
// with periodic REF insertion that always wins over new host requests.
module ddr3_cmd_scheduler
    import ddr3_sched_pkg::*;
#(
    parameter int unsigned T_RCD  = DEF_T_RCD,
    parameter int unsigned T_WR   = DEF_T_WR,
    parameter int unsigned T_RTP  = DEF_T_RTP,
    parameter int unsigned T_RP   = DEF_T_RP,
    parameter int unsigned T_RFC  = DEF_T_RFC,
    parameter int unsigned T_REFI = DEF_T_REFI
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             init_done,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [BA_W-1:0]  req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    input  logic [DQ_W-1:0]  req_wdata,
    output logic             ACT,
    output logic             WRITE,
    output logic             READ,
    output logic             PRE,
    output logic             REF,
    output logic [BA_W-1:0]  BA_in,
    output logic [ROW_W-1:0] Addr_Row,
    output logic [COL_W-1:0] Addr_Column,
    output logic [DQ_W-1:0]  DQ_in,
    output logic             A_10,
    output logic             A_12,
    output logic             Addr_Column_11,
    output logic             done,
    output logic             busy
);

    localparam int unsigned RefiW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

    state_e state_q, state_d;

    logic              write_q;
    logic [BA_W-1:0]   ba_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [DQ_W-1:0]   dq_q;

    logic              capture;
    logic              ref_clear;
    logic              timer_load;
    logic [WAIT_W-1:0] timer_value;
    logic              timer_expired;
    logic              rw_has_wait;

    logic [RefiW-1:0]  refi_cnt_q, refi_cnt_d;
    logic              refi_wrap;
    logic              ref_pending_q, ref_pending_d;

    ddr3_wait_timer #(
        .Width(WAIT_W)
    ) u_wait_timer (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .load_i      (timer_load),
        .load_value_i(timer_value),
        .expired_o   (timer_expired)
    );

    assign rw_has_wait = write_q ? (T_WR > 1) : (T_RTP > 1);

    // RESET gating keeps req_ready low while reset is held, whatever init_done does.
    assign req_ready = ~RESET & (state_q == StIdle) & init_done & ~ref_pending_q;

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        ref_clear   = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        unique case (state_q)
            StIdle: begin
                if (init_done && ref_pending_q) begin
                    state_d = StRef;
                end else if (req_valid && req_ready) begin
                    capture = 1'b1;
                    state_d = StAct;
                end
            end
            StAct: begin
                timer_load  = 1'b1;
                timer_value = wait_load(T_RCD);
                state_d     = (T_RCD > 1) ? StWaitRcd : StRw;
            end
            StWaitRcd: begin
                if (timer_expired) state_d = StRw;
            end
            StRw: begin
                timer_load  = 1'b1;
                timer_value = write_q ? wait_load(T_WR) : wait_load(T_RTP);
                state_d     = rw_has_wait ? StWaitRw : StPre;
            end
            StWaitRw: begin
                if (timer_expired) state_d = StPre;
            end
            StPre: begin
                timer_load  = 1'b1;
                timer_value = wait_load(T_RP);
                state_d     = (T_RP > 1) ? StWaitRp : StIdle;
            end
            StWaitRp: begin
                if (timer_expired) state_d = StIdle;
            end
            StRef: begin
                ref_clear   = 1'b1;
                timer_load  = 1'b1;
                timer_value = wait_load(T_RFC);
                state_d     = (T_RFC > 1) ? StWaitRfc : StIdle;
            end
            StWaitRfc: begin
                if (timer_expired) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Refresh interval counter; a wrap coinciding with REF keeps the flag set.
    always_comb begin
        refi_wrap     = init_done && (refi_cnt_q == RefiW'(T_REFI - 1));
        refi_cnt_d    = refi_cnt_q;
        if (init_done) begin
            refi_cnt_d = refi_wrap ? '0 : refi_cnt_q + 1'b1;
        end
        ref_pending_d = ref_pending_q;
        if (refi_wrap) begin
            ref_pending_d = 1'b1;
        end else if (ref_clear) begin
            ref_pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StIdle;
            refi_cnt_q    <= '0;
            ref_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            refi_cnt_q    <= refi_cnt_d;
            ref_pending_q <= ref_pending_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            write_q <= 1'b0;
            ba_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            dq_q    <= '0;
        end else if (capture) begin
            write_q <= req_write;
            ba_q    <= req_ba;
            row_q   <= req_row;
            col_q   <= req_col;
            dq_q    <= req_wdata;
        end
    end

    assign ACT            = (state_q == StAct);
    assign WRITE          = (state_q == StRw) & write_q;
    assign READ           = (state_q == StRw) & ~write_q;
    assign PRE            = (state_q == StPre);
    assign REF            = (state_q == StRef);
    assign done           = PRE;
    assign busy           = (state_q != StIdle);
    assign BA_in          = ba_q;
    assign Addr_Row       = row_q;
    assign Addr_Column    = col_q;
    assign DQ_in          = dq_q;
    assign A_10           = 1'b0;
    assign A_12           = 1'b0;
    assign Addr_Column_11 = 1'b0;

endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
// Self-checking bench: schedule-based reference model checked every cycle, plus directed
// literal timing checks for write/read latency, refresh spacing, back-to-back and reset abort.
module tb_ddr3_cmd_scheduler;

    localparam int TRCD  = 4;
    localparam int TWR   = 6;
    localparam int TRTP  = 4;
    localparam int TRP   = 4;
    localparam int TRFC  = 16;
    localparam int TREFI = 40;
    localparam int NCYC  = 8192;

    localparam int P_NONE = 0;
    localparam int P_ACT  = 1;
    localparam int P_RD   = 2;
    localparam int P_WR   = 3;
    localparam int P_PRE  = 4;
    localparam int P_REF  = 5;

    logic        CLK       = 1'b0;
    logic        RESET     = 1'b1;
    logic        init_done = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_ba    = '0;
    logic [14:0] req_row   = '0;
    logic [9:0]  req_col   = '0;
    logic [15:0] req_wdata = '0;

    logic        req_ready, ACT, WRITE, READ, PRE, REF;
    logic [2:0]  BA_in;
    logic [14:0] Addr_Row;
    logic [9:0]  Addr_Column;
    logic [15:0] DQ_in;
    logic        A_10, A_12, Addr_Column_11, done, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_pulse [NCYC];

    ddr3_cmd_scheduler #(
        .T_RCD (TRCD),
        .T_WR  (TWR),
        .T_RTP (TRTP),
        .T_RP  (TRP),
        .T_RFC (TRFC),
        .T_REFI(TREFI)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .init_done     (init_done),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_ba        (req_ba),
        .req_row       (req_row),
        .req_col       (req_col),
        .req_wdata     (req_wdata),
        .ACT           (ACT),
        .WRITE         (WRITE),
        .READ          (READ),
        .PRE           (PRE),
        .REF           (REF),
        .BA_in         (BA_in),
        .Addr_Row      (Addr_Row),
        .Addr_Column   (Addr_Column),
        .DQ_in         (DQ_in),
        .A_10          (A_10),
        .A_12          (A_12),
        .Addr_Column_11(Addr_Column_11),
        .done          (done),
        .busy          (busy)
    );

    initial forever #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    function automatic void check(input string nm, input logic [63:0] got,
                                  input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
        end
    endfunction

    function automatic logic [4:0] pulse_vec(input int ep);
        return (ep == P_NONE) ? 5'b0 : 5'(5'b1 << (5 - ep));
    endfunction

    function automatic void sched(input int t, input int code);
        if (t >= 0 && t < NCYC) exp_pulse[t] = code;
    endfunction

    // Reference model: each accepted request books absolute pulse cycles and the cycle the
    // scheduler becomes free again; refresh is a free-running count of init_done cycles.
    initial begin
        int          cnt_m;
        bit          pend_m;
        int          free_at;
        int          ref_at;
        int          ep;
        bit          idle;
        bit          rdy_m;
        bit          wrap;
        int          t_act, t_rw, t_pre;
        logic [2:0]  ba_m;
        logic [14:0] row_m;
        logic [9:0]  col_m;
        logic [15:0] dq_m;
        cnt_m = 0; pend_m = 0; free_at = 0; ref_at = -1;
        ba_m = '0; row_m = '0; col_m = '0; dq_m = '0;
        for (int i = 0; i < NCYC; i++) exp_pulse[i] = P_NONE;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                check("reset_outputs", 64'({ACT, READ, WRITE, PRE, REF, done, busy, req_ready,
                      BA_in, Addr_Row, Addr_Column, DQ_in}), 64'd0);
                cnt_m = 0; pend_m = 0; free_at = 0; ref_at = -1;
                ba_m = '0; row_m = '0; col_m = '0; dq_m = '0;
                for (int i = 0; i < 64; i++) sched(cyc + i, P_NONE);
            end else begin
                ep    = (cyc < NCYC) ? exp_pulse[cyc] : P_NONE;
                idle  = (cyc >= free_at);
                rdy_m = idle && init_done && !pend_m;
                check("pulses", 64'({ACT, READ, WRITE, PRE, REF}), 64'(pulse_vec(ep)));
                check("done", 64'(done), 64'(ep == P_PRE));
                check("busy", 64'(busy), 64'(!idle));
                check("req_ready", 64'(req_ready), 64'(rdy_m));
                check("addr_data", 64'({BA_in, Addr_Row, Addr_Column, DQ_in}),
                      64'({ba_m, row_m, col_m, dq_m}));
                check("const_bits", 64'({A_10, A_12, Addr_Column_11}), 64'd0);
                if (idle && init_done && pend_m) begin
                    ref_at  = cyc + 1;
                    sched(ref_at, P_REF);
                    free_at = ref_at + TRFC;
                end else if (rdy_m && req_valid) begin
                    t_act   = cyc + 1;
                    t_rw    = t_act + TRCD;
                    t_pre   = t_rw + (req_write ? TWR : TRTP);
                    sched(t_act, P_ACT);
                    sched(t_rw, req_write ? P_WR : P_RD);
                    sched(t_pre, P_PRE);
                    free_at = t_pre + TRP;
                    ba_m = req_ba; row_m = req_row; col_m = req_col; dq_m = req_wdata;
                end
                wrap = 0;
                if (init_done) begin
                    if (cnt_m == TREFI - 1) begin
                        cnt_m = 0;
                        wrap  = 1;
                    end else begin
                        cnt_m++;
                    end
                end
                pend_m = wrap || (pend_m && (cyc != ref_at));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic goto_cyc(input int t);
        @(negedge CLK);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic wait_pulse(input int which, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if ((which == P_ACT && ACT === 1'b1) || (which == P_PRE && PRE === 1'b1) ||
                (which == P_REF && REF === 1'b1)) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic send(input logic w, input logic [2:0] ba, input logic [14:0] row,
                        input logic [9:0] col, input logic [15:0] data, output int k);
        tick();
        req_valid = 1'b1; req_write = w; req_ba = ba; req_row = row; req_col = col;
        req_wdata = data;
        k = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (req_ready === 1'b1) begin
                k = cyc;
                break;
            end
        end
        check("send_accepted", 64'(k >= 0), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int k, k2, k3, x, x2, r, rr, a, p, a2, r2, seen;
        int refs[$];
        repeat (3) tick();
        RESET = 1'b0;

        // init_done low: requests must be ignored completely
        req_valid = 1'b1; req_write = 1'b1; req_ba = 3'd5; req_row = 15'h1234;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (req_ready || ACT || READ || WRITE || PRE || REF || busy) seen = 1;
        end
        check("no_activity_before_init", 64'(seen), 64'd0);
        tick();
        req_valid = 1'b0;
        init_done = 1'b1;
        x = cyc;

        send(1'b1, 3'b011, 15'd5, 10'd7, 16'hF00F, k);
        check("wr_accept_cycle", 64'(k), 64'(x + 1));
        goto_cyc(k + 1);
        check("wr_act", 64'({ACT, Addr_Row, DQ_in}), 64'({1'b1, 15'd5, 16'hF00F}));
        goto_cyc(k + 5);
        check("wr_write", 64'({WRITE, READ, Addr_Column}), 64'({1'b1, 1'b0, 10'd7}));
        goto_cyc(k + 11);
        check("wr_pre_done", 64'({PRE, done, BA_in, Addr_Row, DQ_in}),
              64'({2'b11, 3'b011, 15'd5, 16'hF00F}));
        goto_cyc(k + 14);
        check("wr_ready_low", 64'(req_ready), 64'd0);
        goto_cyc(k + 15);
        check("wr_ready_back", 64'(req_ready), 64'd1);

        send(1'b0, 3'b010, 15'h5D6E, 10'h3F8, 16'h1111, k2);
        goto_cyc(k2 + 1);
        check("rd_act", 64'({ACT, A_10, Addr_Row}), 64'({1'b1, 1'b0, 15'h5D6E}));
        goto_cyc(k2 + 5);
        check("rd_read", 64'({READ, WRITE, A_10, Addr_Column}), 64'({2'b10, 1'b0, 10'h3F8}));
        goto_cyc(k2 + 9);
        check("rd_pre", 64'({PRE, done, A_10, BA_in}), 64'({2'b11, 1'b0, 3'b010}));

        // idle host: REF every TREFI cycles, first one TREFI+1 after init_done rose
        for (int i = 0; i < 200 && refs.size() < 3; i++) begin
            @(negedge CLK);
            if (REF === 1'b1) refs.push_back(cyc);
        end
        check("ref_count", 64'(refs.size()), 64'd3);
        r = (refs.size() == 3) ? refs[2] : cyc;
        if (refs.size() == 3) begin
            check("ref_first", 64'(refs[0]), 64'(x + 41));
            check("ref_interval_1", 64'(refs[1] - refs[0]), 64'd40);
            check("ref_interval_2", 64'(refs[2] - refs[1]), 64'd40);
        end

        // request raised as ref_pending sets: REF first, ACT 17 cycles later, then back-to-back
        goto_cyc(r + 38);
        tick();
        req_valid = 1'b1; req_write = 1'b1; req_ba = 3'd6; req_row = 15'h0A0A;
        req_col = 10'h155; req_wdata = 16'hBEEF;
        wait_pulse(P_REF, rr);
        check("ref_before_req", 64'(rr), 64'(r + 40));
        wait_pulse(P_ACT, a);
        check("act_after_ref", 64'(a), 64'(rr + 17));
        wait_pulse(P_PRE, p);
        check("b2b_first_pre", 64'(p), 64'(a + 10));
        wait_pulse(P_ACT, a2);
        check("b2b_second_act", 64'(a2), 64'(p + 5));
        tick();
        req_valid = 1'b0;

        // reset during W_RCD aborts the transaction and restarts the refresh interval
        send(1'b0, 3'd1, 15'h7FFF, 10'h001, 16'h0, k3);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        x2 = cyc;
        seen = 0;
        r2 = -1;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            if (ACT || READ || WRITE || PRE) seen = 1;
            if (REF === 1'b1) begin
                r2 = cyc;
                break;
            end
        end
        check("no_cmd_after_reset", 64'(seen), 64'd0);
        check("ref_after_reset", 64'(r2), 64'(x2 + 41));

        for (int i = 0; i < 2000; i++) begin
            tick();
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_ba    = 3'($urandom);
            req_row   = 15'($urandom);
            req_col   = 10'($urandom);
            req_wdata = 16'($urandom);
            if ($urandom_range(0, 59) == 0) init_done = ~init_done;
        end
        tick();
        req_valid = 1'b0;
        init_done = 1'b1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
